// File: rtl/clk_alu_pkg.sv
// Shared op encodings, flag layout and payload types for the pipelined
// two-operand ALU.
package clk_alu_pkg;

   localparam int unsigned OP_W   = 3;
   localparam int unsigned FLAG_W = 3;

   typedef logic [OP_W-1:0] op_t;

   localparam op_t OP_AND   = 3'd0;
   localparam op_t OP_OR    = 3'd1;
   localparam op_t OP_XOR   = 3'd2;
   localparam op_t OP_ADD   = 3'd3;
   localparam op_t OP_SUB   = 3'd4;
   localparam op_t OP_ACC   = 3'd5;
   localparam op_t OP_SADD  = 3'd6;
   localparam op_t OP_RDACC = 3'd7;

   localparam int unsigned FLAG_ZERO  = 0;
   localparam int unsigned FLAG_CARRY = 1;
   localparam int unsigned FLAG_OVF   = 2;

   // Field order places each flag at its FLAG_* bit index.
   typedef struct packed {
      logic ovf;
      logic carry;
      logic zero;
   } flags_t;

endpackage

// File: rtl/clk_alu_pipe_if.sv
// Operand/result handshake bundle between a beat producer and clk_alu_pipe.
interface clk_alu_pipe_if #(
   parameter int unsigned WIDTH = 8
);
   import clk_alu_pkg::*;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   op_t              op;
   logic             acc_clr;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] y;
   flags_t           flags;

   modport master (
      output in_valid, a, b, op, acc_clr, out_ready,
      input  in_ready, out_valid, y, flags
   );

   modport slave (
      input  in_valid, a, b, op, acc_clr, out_ready,
      output in_ready, out_valid, y, flags
   );

endinterface

// File: rtl/clk_alu_core.sv
// Combinational datapath: one operation on (a, b, acc) producing the result,
// status flags and the accumulator write-back.
module clk_alu_core
   import clk_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   input  op_t              op,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] next_acc,
   output logic             acc_we,
   output flags_t           flags
);

   localparam int unsigned MSB = WIDTH - 1;

   logic [WIDTH:0] add_ab_c;
   logic [WIDTH:0] sub_ab_c;
   logic [WIDTH:0] add_acc_c;
   logic           ovf_c;
   logic           carry_c;

   // Extra top bit carries the unsigned carry-out, or the borrow for SUB.
   assign add_ab_c  = {1'b0, a} + {1'b0, b};
   assign sub_ab_c  = {1'b0, a} - {1'b0, b};
   assign add_acc_c = {1'b0, acc} + {1'b0, a};

   always_comb begin
      result   = '0;
      next_acc = acc;
      acc_we   = 1'b0;
      ovf_c    = 1'b0;
      carry_c  = 1'b0;
      case (op)
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_ADD: begin
            result  = add_ab_c[WIDTH-1:0];
            carry_c = add_ab_c[WIDTH];
            ovf_c   = (a[MSB] == b[MSB]) && (add_ab_c[MSB] != a[MSB]);
         end
         OP_SUB: begin
            result  = sub_ab_c[WIDTH-1:0];
            carry_c = sub_ab_c[WIDTH];
            ovf_c   = (a[MSB] != b[MSB]) && (sub_ab_c[MSB] != a[MSB]);
         end
         OP_ACC: begin
            result   = add_acc_c[WIDTH-1:0];
            next_acc = add_acc_c[WIDTH-1:0];
            acc_we   = 1'b1;
            carry_c  = add_acc_c[WIDTH];
            ovf_c    = (acc[MSB] == a[MSB]) && (add_acc_c[MSB] != acc[MSB]);
         end
         OP_SADD: begin
            carry_c = add_ab_c[WIDTH];
            result  = add_ab_c[WIDTH] ? '1 : add_ab_c[WIDTH-1:0];
         end
         OP_RDACC: result = acc;
         default: result = '0;
      endcase
   end

   assign flags.ovf   = ovf_c;
   assign flags.carry = carry_c;
   assign flags.zero  = (result == '0);

endmodule

// File: rtl/clk_alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds the accepted operands, S2 holds
// the registered result; the running accumulator updates on each S1->S2 move.
module clk_alu_pipe
   import clk_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   clk_alu_pipe_if.slave  bus
);

   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   op_t              s1_op;

   logic             s2_valid;
   logic [WIDTH-1:0] s2_y;
   flags_t           s2_flags;

   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_base_c;

   logic             s2_adv_c;
   logic             accept_c;

   logic [WIDTH-1:0] core_result_c;
   logic [WIDTH-1:0] core_next_acc_c;
   logic             core_acc_we_c;
   flags_t           core_flags_c;

   // Handshake: S1 may refill in the same cycle it hands its beat to S2.
   assign s2_adv_c     = s1_valid && (!s2_valid || bus.out_ready);
   assign bus.in_ready = (!s1_valid || s2_adv_c) && rst_n;
   assign accept_c     = bus.in_valid && bus.in_ready;

   // A clear on the transfer edge makes the moving beat see a zero accumulator.
   assign acc_base_c = bus.acc_clr ? '0 : acc_q;

   clk_alu_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a        (s1_a),
      .b        (s1_b),
      .acc      (acc_base_c),
      .op       (s1_op),
      .result   (core_result_c),
      .next_acc (core_next_acc_c),
      .acc_we   (core_acc_we_c),
      .flags    (core_flags_c)
   );

   // Stage 1: operand capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= OP_AND;
      end else if (accept_c) begin
         s1_valid <= 1'b1;
         s1_a     <= bus.a;
         s1_b     <= bus.b;
         s1_op    <= bus.op;
      end else if (s2_adv_c) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2: result register, held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_y     <= '0;
         s2_flags <= '0;
      end else if (s2_adv_c) begin
         s2_valid <= 1'b1;
         s2_y     <= core_result_c;
         s2_flags <= core_flags_c;
      end else if (bus.out_ready) begin
         s2_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (s2_adv_c && core_acc_we_c) begin
         acc_q <= core_next_acc_c;
      end else if (bus.acc_clr) begin
         acc_q <= '0;
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.y         = s2_y;
   assign bus.flags     = s2_flags;

endmodule

// File: tb/tb_clk_alu_pipe.sv
// Self-checking bench: WIDTH=8 and WIDTH=16 pipelines driven in lockstep,
// checked against a table of constants and a queue-based reference model.
module tb_clk_alu_pipe;
   import clk_alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        s_valid, s_clr, s_ready;
   logic [15:0] s_a, s_b;
   logic [2:0]  s_op;

   clk_alu_pipe_if #(.WIDTH(8))  if8 ();
   clk_alu_pipe_if #(.WIDTH(16)) if16 ();

   assign if8.in_valid  = s_valid;
   assign if8.a         = s_a[7:0];
   assign if8.b         = s_b[7:0];
   assign if8.op        = s_op;
   assign if8.acc_clr   = s_clr;
   assign if8.out_ready = s_ready;
   assign if16.in_valid  = s_valid;
   assign if16.a         = s_a;
   assign if16.b         = s_b;
   assign if16.op        = s_op;
   assign if16.acc_clr   = s_clr;
   assign if16.out_ready = s_ready;

   clk_alu_pipe #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
   clk_alu_pipe #(.WIDTH(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

   int nvec = 0;
   int nerr = 0;

   logic [10:0] q8[$];
   logic [18:0] q16[$];
   logic [15:0] macc8  = '0;
   logic [15:0] macc16 = '0;

   typedef struct {
      string      name;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic       clr;
      logic [7:0] y;
      logic [2:0] f;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic int sgn(input int unsigned x, input int unsigned w);
      return (x >= (32'd1 << (w - 1))) ? int'(x) - int'(32'd1 << w) : int'(x);
   endfunction

   function automatic logic out_of_range(input int s, input int unsigned w);
      return (s > int'((32'd1 << (w - 1)) - 1)) || (s < -int'(32'd1 << (w - 1)));
   endfunction

   // Reference: integer arithmetic, signed overflow judged by range.
   function automatic logic [18:0] model(input int unsigned w, input logic [2:0] op,
                                         input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] acc, output logic [15:0] nacc);
      int unsigned m, ua, ub, uc, sum, r;
      logic c, o;
      m  = (32'd1 << w) - 1;
      ua = 32'(a) & m;
      ub = 32'(b) & m;
      uc = 32'(acc) & m;
      c = 1'b0; o = 1'b0; r = 0;
      nacc = 16'(uc);
      case (op)
         OP_AND: r = ua & ub;
         OP_OR:  r = ua | ub;
         OP_XOR: r = ua ^ ub;
         OP_ADD: begin
            sum = ua + ub; r = sum & m; c = (sum > m);
            o = out_of_range(sgn(ua, w) + sgn(ub, w), w);
         end
         OP_SUB: begin
            r = (ua - ub) & m; c = (ua < ub);
            o = out_of_range(sgn(ua, w) - sgn(ub, w), w);
         end
         OP_ACC: begin
            sum = uc + ua; r = sum & m; c = (sum > m);
            o = out_of_range(sgn(uc, w) + sgn(ua, w), w);
            nacc = 16'(r);
         end
         OP_SADD: begin
            sum = ua + ub;
            if (sum > m) begin r = m; c = 1'b1; end
            else r = sum;
         end
         default: r = uc;
      endcase
      return {o, c, (r == 0), 16'(r)};
   endfunction

   // Scoreboard: push on accept, pop on output transfer (sampled mid-cycle).
   always @(negedge clk) begin
      logic [18:0] e;
      logic [15:0] na;
      logic [10:0] e8;
      if (rst_n) begin
         if (if8.out_valid && if8.out_ready) begin
            if (q8.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL sb8_extra: got output %0h, expected none", if8.y);
            end else begin
               e8 = q8.pop_front();
               chk("sb8", 32'({if8.flags, if8.y}), 32'(e8));
            end
         end
         if (if16.out_valid && if16.out_ready) begin
            if (q16.size() == 0) begin
               nvec++; nerr++;
               $display("FAIL sb16_extra: got output %0h, expected none", if16.y);
            end else begin
               e = q16.pop_front();
               chk("sb16", 32'({if16.flags, if16.y}), 32'(e));
            end
         end
         if (if8.in_valid && if8.in_ready) begin
            e = model(8, s_op, s_a, s_b, s_clr ? 16'd0 : macc8, na);
            q8.push_back({e[18:16], e[7:0]});
            macc8 = na;
         end
         if (if16.in_valid && if16.in_ready) begin
            e = model(16, s_op, s_a, s_b, s_clr ? 16'd0 : macc16, na);
            q16.push_back(e);
            macc16 = na;
         end
      end
   end

   // One beat with an empty pipeline; acc_clr held through accept and transfer.
   task automatic apply_vec(input vec_t v);
      int n;
      @(posedge clk); #1;
      s_valid = 1'b1; s_op = v.op; s_a = 16'(v.a); s_b = 16'(v.b); s_clr = v.clr;
      n = 0;
      do begin @(negedge clk); n++; end while (!if8.in_ready && n < 20);
      if (!if8.in_ready) begin
         nvec++; nerr++;
         $display("FAIL %s_accept: got in_ready 0, expected 1 within 20 cycles", v.name);
         s_valid = 1'b0; s_clr = 1'b0;
         return;
      end
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(posedge clk); #1;
      s_clr = 1'b0;
      chk({v.name, "_lat"}, 32'(if8.out_valid), 32'd1);
      chk({v.name, "_y"}, 32'(if8.y), 32'(v.y));
      chk({v.name, "_f"}, 32'(if8.flags), 32'(v.f));
   endtask

   task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      s_valid = 1'b1; s_op = op; s_a = a; s_b = b;
   endtask

   vec_t tbl[16];

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before 500000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic fired;
      int   n;
      tbl[0]  = '{"add_carry", OP_ADD,   8'd200, 8'd100, 1'b0, 8'd44,  3'b010};
      tbl[1]  = '{"add_ovf",   OP_ADD,   8'h7F,  8'h01,  1'b0, 8'h80,  3'b100};
      tbl[2]  = '{"sub_borrow",OP_SUB,   8'd5,   8'd7,   1'b0, 8'hFE,  3'b010};
      tbl[3]  = '{"sadd_sat",  OP_SADD,  8'd200, 8'd100, 1'b0, 8'hFF,  3'b010};
      tbl[4]  = '{"xor_zero",  OP_XOR,   8'h5A,  8'h5A,  1'b0, 8'h00,  3'b001};
      tbl[5]  = '{"and",       OP_AND,   8'hF0,  8'h3C,  1'b0, 8'h30,  3'b000};
      tbl[6]  = '{"or",        OP_OR,    8'hA0,  8'h05,  1'b0, 8'hA5,  3'b000};
      tbl[7]  = '{"sub_ovf",   OP_SUB,   8'h80,  8'h01,  1'b0, 8'h7F,  3'b100};
      tbl[8]  = '{"add_wrap",  OP_ADD,   8'hFF,  8'h01,  1'b0, 8'h00,  3'b011};
      tbl[9]  = '{"sadd",      OP_SADD,  8'd10,  8'd20,  1'b0, 8'd30,  3'b000};
      tbl[10] = '{"acc_clr",   OP_ACC,   8'd5,   8'd0,   1'b1, 8'd5,   3'b000};
      tbl[11] = '{"rdacc",     OP_RDACC, 8'd0,   8'd0,   1'b0, 8'd5,   3'b000};
      tbl[12] = '{"rdacc_clr", OP_RDACC, 8'd0,   8'd0,   1'b1, 8'd0,   3'b001};
      tbl[13] = '{"acc_80",    OP_ACC,   8'h80,  8'd0,   1'b0, 8'h80,  3'b000};
      tbl[14] = '{"acc_wrap",  OP_ACC,   8'h80,  8'd0,   1'b0, 8'h00,  3'b111};
      tbl[15] = '{"sub_zero",  OP_SUB,   8'h33,  8'h33,  1'b0, 8'h00,  3'b001};

      rst_n = 1'b0; s_valid = 1'b0; s_clr = 1'b0; s_ready = 1'b1;
      s_a = '0; s_b = '0; s_op = OP_AND;
      #12;
      chk("rst_in_ready",  32'(if8.in_ready),  32'd0);
      chk("rst_out_valid", 32'(if8.out_valid), 32'd0);
      chk("rst_y",         32'(if8.y),         32'd0);
      chk("rst_flags",     32'(if8.flags),     32'd0);
      @(posedge clk); #1; rst_n = 1'b1;

      // Back-to-back ACC: one result per cycle.
      @(posedge clk); #1; drive(OP_ACC, 16'd10, 16'd0);
      @(posedge clk); #1; drive(OP_ACC, 16'd20, 16'd0);
      @(posedge clk); #1; drive(OP_ACC, 16'd30, 16'd0);
      chk("b2b_v0", 32'(if8.out_valid), 32'd1);
      chk("b2b_y0", 32'(if8.y), 32'd10);
      @(posedge clk); #1; s_valid = 1'b0;
      chk("b2b_y1", 32'(if8.y), 32'd30);
      @(posedge clk); #1;
      chk("b2b_y2", 32'(if8.y), 32'd60);
      @(posedge clk); #1;
      chk("b2b_idle", 32'(if8.out_valid), 32'd0);

      for (int i = 0; i < 16; i++) apply_vec(tbl[i]);

      // Backpressure: two beats fill the pipe, the third waits.
      @(posedge clk); #1; s_ready = 1'b0; drive(OP_ADD, 16'd1, 16'd2);
      @(posedge clk); #1;
      chk("stall_rdy1", 32'(if8.in_ready), 32'd1);
      drive(OP_XOR, 16'h00F0, 16'h000F);
      @(posedge clk); #1;
      drive(OP_SUB, 16'd9, 16'd4);
      chk("stall_rdy3", 32'(if8.in_ready), 32'd0);
      chk("stall_v",    32'(if8.out_valid), 32'd1);
      chk("stall_y",    32'(if8.y), 32'd3);
      repeat (3) begin
         @(posedge clk); #1;
         chk("hold_rdy", 32'(if8.in_ready), 32'd0);
         chk("hold_y",   32'(if8.y), 32'd3);
      end
      s_ready = 1'b1; #1;
      chk("release_rdy", 32'(if8.in_ready), 32'd1);
      @(posedge clk); #1; s_valid = 1'b0;
      chk("release_y", 32'(if8.y), 32'hFF);
      @(posedge clk); #1;
      chk("release_y2", 32'(if8.y), 32'd5);
      repeat (2) @(posedge clk);

      // Reset with both stages full and a nonzero accumulator.
      @(posedge clk); #1; s_ready = 1'b0; drive(OP_ACC, 16'd3, 16'd0);
      @(posedge clk); #1; drive(OP_ACC, 16'd4, 16'd0);
      @(posedge clk); #1; s_valid = 1'b0;
      @(posedge clk); #1; rst_n = 1'b0; #1;
      chk("mrst_out_valid", 32'(if8.out_valid), 32'd0);
      chk("mrst_in_ready",  32'(if8.in_ready),  32'd0);
      chk("mrst_y",         32'(if8.y),         32'd0);
      q8.delete(); q16.delete(); macc8 = '0; macc16 = '0;
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1; s_ready = 1'b1;
      apply_vec('{"acc7_after_rst", OP_ACC, 8'd7, 8'd0, 1'b0, 8'd7, 3'b000});

      // Random valid/ready/op stress, both widths against the model.
      for (int i = 0; i < 800; i++) begin
         @(negedge clk); fired = s_valid && if8.in_ready;
         @(posedge clk); #1;
         if (fired || !s_valid) begin
            s_valid = ($urandom_range(0, 3) != 0);
            s_a = 16'($urandom); s_b = 16'($urandom);
            s_op = 3'($urandom_range(0, 7));
         end
         s_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1; s_valid = 1'b0; s_ready = 1'b1;
      n = 0;
      while ((q8.size() != 0 || q16.size() != 0) && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      chk("drain8",  32'(q8.size()),  32'd0);
      chk("drain16", 32'(q16.size()), 32'd0);
      chk("final_idle", 32'(if8.out_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/clk_alu_pipe.md
# clk_alu_pipe

Parametrised, two-stage pipelined operand processor that generalises the clocked two-operand block behind the `tt_um_*` wrapper. It adds:

- selectable operations,
- a running accumulator,
- status flags,
- a valid/ready handshake with backpressure.

It sits between the wrapper's input pins (`ui_in` → a, `uio_in` → b) and `uo_out`, with `WIDTH` scaling beyond the 8-bit pin budget for reuse.

## Interface
Parameters:
- `WIDTH`, 8, operand/result/accumulator width (≥2).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  operand beat offered.
- `in_ready`  out  1  block accepts beat this cycle.
- `a`  in  WIDTH  operand A.
- `b`  in  WIDTH  operand B.
- `op`  in  3  operation select, sampled with the beat.
- `acc_clr`  in  1  synchronous accumulator clear.
- `out_valid`  out  1  result beat present.
- `out_ready`  in  1  downstream accepts result.
- `y`  out  WIDTH  result.
- `flags`  out  3  {ovf, carry, zero}, aligned with `y`.

## Operation
- Ops:
  - 0 AND, 1 OR, 2 XOR: carry = 0, ovf = 0.
  - 3 ADD: y = a+b mod 2^WIDTH; carry = unsigned carry-out; ovf = signed overflow.
  - 4 SUB: y = a−b mod 2^WIDTH; carry = borrow (a<b unsigned); ovf = signed overflow.
  - 5 ACC: acc ← acc+a; y = new acc; carry/ovf as ADD on (acc, a).
  - 6 SADD: unsigned saturating add; y = all-ones and carry = 1 on overflow; ovf = 0.
  - 7 RDACC: y = acc; acc unchanged; carry = ovf = 0.
- zero = (y == 0) for every op.
- Stage 1 (S1) registers a, b and op on an accepted beat (`in_valid && in_ready`).
- Stage 2 (S2) computes on S1 contents and registers y/flags; the accumulator updates on the same S1→S2 transfer. Accumulator order therefore equals acceptance order.
- Each stage holds one beat; capacity is 2 beats.
- Stage advance:
  - s2_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = (!s1_valid || s2_adv) && rst_n.
- `acc_clr` zeroes acc at the next edge.
  - If an ACC op transfers on that edge, it uses base 0 (y = a, acc = a).
  - With RDACC, y = 0.
  - `acc_clr` never affects beats already in S2.
- Accumulator wraps modulo 2^WIDTH; no saturation.
- Output data is held stable while `out_valid && !out_ready`.

## Timing
- Latency: beat accepted at edge N → `out_valid` high after edge N+1 (two edges) if unstalled.
- Throughput: one beat per cycle with `out_ready` held high.
- While `rst_n` is low: `in_ready`=0, `out_valid`=0, `y`=0, `flags`=0, acc=0, all stage valids cleared.
- Reset mid-operation drops in-flight beats with no partial output. The first beat after release sees acc = 0.
- Simultaneous S2 drain and S1 refill in one cycle is lossless. So is simultaneous input accept and S1→S2 transfer.
- `in_ready` depends combinationally on `out_ready`. No combinational path exists from `in_valid` to `out_valid`.

## Structure
- Package `clk_alu_pkg`:
  - op localparams: OP_AND … OP_RDACC.
  - flag bit indices: FLAG_ZERO = 0, FLAG_CARRY = 1, FLAG_OVF = 2.
- Sub-module `clk_alu_core`: purely combinational (a, b, acc, op) → (result, next_acc, acc_we, flags).
- The top module owns the stage registers, the handshake and the accumulator register.
- The wrapper instantiates with WIDTH=8 and ties valid/ready high.

## Test plan
- ADD a=200, b=100, out_ready=1 → y=44 two edges after accept, carry=1, ovf=0, zero=0. Then ADD 0x7F+0x01 → y=0x80, ovf=1, carry=0.
- SUB 5−7 → y=0xFE, carry=1; SADD 200+100 → y=0xFF, carry=1; XOR 0x5A^0x5A → y=0, zero=1.
- Back-to-back ACC 10, 20, 30 → y=10, 30, 60 on consecutive cycles. Then ACC 5 with `acc_clr` → y=5. RDACC → y=5.
- out_ready=0 with 3 beats offered → 2 accepted, in_ready=0 on the third. y is held stable. Release → outputs in order, third beat then accepted, nothing lost or duplicated.
- Reset asserted with both stages full → out_valid=0 and in_ready=0 immediately. After release, ACC 7 → y=7.
- Random op/operand/valid/ready stress against a reference model for WIDTH=8 and WIDTH=16 → zero mismatches, order preserved.
